// File: rtl/label_search_if.sv
// rtl/label_search_if.sv - request/response and table-write bundle for label_search
//
// Purpose: groups the table write port, the search request/response
// handshakes and the busy flag of label_search. Clock and reset stay plain
// module ports.
//
// Parameters:
//   IDX_W   label index width
//   ADDR_W  address width
//
// Signals (direction as seen by the slave, i.e. label_search):
//   wr_en      in   table write strobe
//   wr_idx     in   entry to write
//   wr_addr    in   address stored into the entry (also sets its valid bit)
//   req_valid  in   search request
//   req_ready  out  high only while idle
//   req_addr   in   address to search for
//   rsp_valid  out  result available
//   rsp_ready  in   consumer accepts result
//   rsp_hit    out  1 = match found
//   rsp_idx    out  matching index, 0 on miss
//   busy       out  high while scanning or holding a response
//
// Modports: master (requester / table programmer), slave (label_search).

interface label_search_if #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 16
);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_addr;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;

  logic              busy;

  modport master (
    output wr_en, wr_idx, wr_addr,
    output req_valid, req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_hit, rsp_idx,
    input  busy
  );

  modport slave (
    input  wr_en, wr_idx, wr_addr,
    input  req_valid, req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_hit, rsp_idx,
    output busy
  );

endinterface

// File: rtl/label_search.sv
// rtl/label_search.sv - reverse jump-label resolver (address -> label index)
//
// Purpose: holds a programmable table of NUM_LABELS {valid, addr} entries and
// answers "which label holds this address?" by scanning one entry per clock
// in ascending index order, so the lowest matching index wins.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   bus      label_search_if.slave
//            wr_en/wr_idx/wr_addr   table write (accepted in every state)
//            req_valid/req_ready/req_addr   search request
//            rsp_valid/rsp_ready/rsp_hit/rsp_idx   search response
//            busy                   high while scanning or responding
//
// Parameters:
//   NUM_LABELS  number of table entries (must be <= 2**IDX_W)
//   IDX_W       label index width
//   ADDR_W      address width
//
// Build option:
//   LABEL_SEARCH_PRELOAD_EN  when defined, reset loads entries 0..8 with a
//                            fixed set of valid addresses instead of
//                            clearing the whole table.
//
// Every output except req_ready comes straight from a flop; req_ready is a
// decode of the state register.

module label_search #(
  parameter int NUM_LABELS = 16,
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  label_search_if.slave bus
);

  localparam logic [IDX_W-1:0] last_idx    = IDX_W'(NUM_LABELS - 1);
  localparam logic [IDX_W:0]   num_entries = (IDX_W + 1)'(NUM_LABELS);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_scan = 2'd1,
    st_resp = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Label table.
  logic              valid_q [NUM_LABELS];
  logic [ADDR_W-1:0] addr_q  [NUM_LABELS];

  // Search datapath.
  logic [ADDR_W-1:0] key_q;
  logic [IDX_W-1:0]  cnt_q;

  // Registered outputs.
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic [IDX_W-1:0]  rsp_idx_q;
  logic              busy_q;

  logic accept;
  logic entry_match;
  logic scan_last;
  logic wr_in_range;

`ifdef LABEL_SEARCH_PRELOAD_EN
  // Reset image of the table in the preload build.
  function automatic logic [ADDR_W-1:0] preload_addr(input int i);
    case (i)
      0:       return ADDR_W'(10);
      1:       return ADDR_W'(22);
      2:       return ADDR_W'(76);
      3:       return ADDR_W'(101);
      4:       return ADDR_W'(123);
      5:       return ADDR_W'(131);
      6:       return ADDR_W'(8);
      7:       return ADDR_W'(37);
      8:       return ADDR_W'(16);
      default: return '0;
    endcase
  endfunction

  function automatic logic preload_valid(input int i);
    return (i < 9);
  endfunction
`endif

  assign accept      = bus.req_valid && (state_q == st_idle);
  // The compare reads the registered table, so a write landing on the same
  // edge as the compare of that entry is only seen from the next cycle on.
  assign entry_match = valid_q[cnt_q] && (addr_q[cnt_q] == key_q);
  assign scan_last   = (cnt_q == last_idx);
  // Writes to indices beyond the table are dropped.
  assign wr_in_range = ({1'b0, bus.wr_idx} < num_entries);

  // ---------------------------------------------------------------------------
  // Label table: reset image, then writes in any state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
`ifdef LABEL_SEARCH_PRELOAD_EN
        valid_q[i] <= preload_valid(i);
        addr_q[i]  <= preload_addr(i);
`else
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
`endif
      end
    end else if (bus.wr_en && wr_in_range) begin
      valid_q[bus.wr_idx] <= 1'b1;
      addr_q[bus.wr_idx]  <= bus.wr_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (bus.req_valid) begin
          state_d = st_scan;
        end
      end
      st_scan: begin
        if (entry_match || scan_last) begin
          state_d = st_resp;
        end
      end
      st_resp: begin
        // rsp_valid is high for the whole of this state, so rsp_ready alone
        // completes the handshake.
        if (bus.rsp_ready) begin
          state_d = st_idle;
        end
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Search datapath and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Output flags track the state being entered so they line up with it.
      rsp_valid_q <= (state_d == st_resp);
      busy_q      <= (state_d != st_idle);

      if (accept) begin
        key_q <= bus.req_addr;
        cnt_q <= '0;
      end

      if (state_q == st_scan) begin
        if (entry_match) begin
          rsp_hit_q <= 1'b1;
          rsp_idx_q <= cnt_q;
        end else if (scan_last) begin
          rsp_hit_q <= 1'b0;
          rsp_idx_q <= '0;
        end else begin
          cnt_q <= cnt_q + IDX_W'(1);
        end
      end
    end
  end

  assign bus.req_ready = (state_q == st_idle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.busy      = busy_q;

endmodule
